rfbw_dchit_nway: RTL and testbench

RFBW_DCHIT_NWAY -- requirements
Module: rfbw_dchit_nway

---
 rtl/rfbw_dchit_nway.sv | 145 ++++++++++++++
 tb/tb_rfbw_dchit_nway.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfbw_dchit_nway.sv
// rfbw_dchit_nway: N-way D-cache hit/victim lookup stage.
// Holds per-line valid bits and per-set round-robin pointers.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req_v, adr, tags   lookup request, address, per-way tags of the set
//   stall              freezes lookup outputs, drops req_v
//   fill_v/way/ndx     mark one line valid, advance set RR pointer
//   inv_v/inv_ndx      clear all ways of one set
//   inv_all            clear every valid bit
//   hit_v, hits, hit   registered lookup result
//   rway, multi_hit    lowest hitting way, more-than-one-hit flag
//   victim             replacement way for the looked-up set
module rfbw_dchit_nway #(
  parameter int AWID  = 32,
  parameter int WAYS  = 4,
  parameter int LINES = 128,
  parameter int LOBIT = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_v,
  input  logic [AWID-1:0]                     adr,
  input  logic [WAYS-1:0][AWID-LOBIT-1:0]     tags,
  input  logic                                stall,
  input  logic                                fill_v,
  input  logic [$clog2(WAYS)-1:0]             fill_way,
  input  logic [$clog2(LINES)-1:0]            fill_ndx,
  input  logic                                inv_v,
  input  logic [$clog2(LINES)-1:0]            inv_ndx,
  input  logic                                inv_all,
  output logic                                hit_v,
  output logic [WAYS-1:0]                     hits,
  output logic                                hit,
  output logic [$clog2(WAYS)-1:0]             rway,
  output logic                                multi_hit,
  output logic [$clog2(WAYS)-1:0]             victim
);

  localparam int NDXW = $clog2(LINES);
  localparam int WAYW = $clog2(WAYS);
  localparam int TAGW = AWID - LOBIT;

  logic [WAYS-1:0] r_valid [LINES];
  logic [WAYW-1:0] r_ptr   [LINES];

  logic            r_hit_v;
  logic [WAYS-1:0] r_hits;
  logic            r_hit;
  logic [WAYW-1:0] r_rway;
  logic            r_multi;
  logic [WAYW-1:0] r_victim;

  logic [TAGW-1:0] w_tag;
  logic [NDXW-1:0] w_ndx;
  logic [WAYS-1:0] w_vset;
  logic [WAYW-1:0] w_pset;
  logic [WAYS-1:0] w_hits;
  logic [WAYW-1:0] w_hway;
  logic [WAYW-1:0] w_vic;
  logic            w_multi;
  logic            w_unused;

  assign w_tag    = adr[AWID-1:LOBIT];
  assign w_ndx    = adr[LOBIT+NDXW-1:LOBIT];
  assign w_vset   = r_valid[w_ndx];
  assign w_pset   = r_ptr[w_ndx];
  assign w_unused = ^adr[LOBIT-1:0];

  always_comb begin
    w_hits = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_hits[w] = (tags[w] == w_tag) && w_vset[w];
    end
  end

  // Scan downward so the lowest-numbered match wins.
  always_comb begin
    w_hway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hits[w]) w_hway = WAYW'(w);
    end
  end

  // Lowest invalid way, otherwise the set's RR pointer.
  always_comb begin
    w_vic = w_pset;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_vset[w]) w_vic = WAYW'(w);
    end
  end

  // More than one bit set iff clearing the lowest leaves something.
  assign w_multi = (w_hits & (w_hits - WAYS'(1))) != '0;

  // Later assignment wins: inv_v overrides a fill to the same set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        r_valid[i] <= '0;
        r_ptr[i]   <= '0;
      end
    end else begin
      if (fill_v) begin
        r_ptr[fill_ndx] <= r_ptr[fill_ndx] + WAYW'(1);
      end
      if (inv_all) begin
        for (int i = 0; i < LINES; i++) begin
          r_valid[i] <= '0;
        end
      end else begin
        if (fill_v) r_valid[fill_ndx][fill_way] <= 1'b1;
        if (inv_v)  r_valid[inv_ndx] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_v  <= 1'b0;
      r_hits   <= '0;
      r_hit    <= 1'b0;
      r_rway   <= '0;
      r_multi  <= 1'b0;
      r_victim <= '0;
    end else if (!stall) begin
      r_hit_v <= req_v;
      if (req_v) begin
        r_hits   <= w_hits;
        r_hit    <= |w_hits;
        r_multi  <= w_multi;
        r_victim <= w_vic;
        if (|w_hits) r_rway <= w_hway;
      end
    end
  end

  assign hit_v     = r_hit_v;
  assign hits      = r_hits;
  assign hit       = r_hit;
  assign rway      = r_rway;
  assign multi_hit = r_multi;
  assign victim    = r_victim;

endmodule

// File: tb/tb_rfbw_dchit_nway.sv
// tb_rfbw_dchit_nway: scoreboard bench for rfbw_dchit_nway.
// Directed scenarios then randomized traffic vs a reference model.
module tb_rfbw_dchit_nway;

  localparam int AWID  = 32;
  localparam int WAYS  = 4;
  localparam int LINES = 128;
  localparam int LOBIT = 6;
  localparam int NDXW  = 7;
  localparam int WAYW  = 2;
  localparam int TAGW  = AWID - LOBIT;
  localparam int UPW   = TAGW - NDXW;

  typedef logic [WAYS-1:0][TAGW-1:0] tg_t;

  typedef struct packed {
    logic            hv;
    logic [WAYS-1:0] hits;
    logic            hit;
    logic [WAYW-1:0] rway;
    logic            mh;
    logic [WAYW-1:0] vic;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_v;
  logic [AWID-1:0] adr;
  tg_t             tags;
  logic            stall;
  logic            fill_v;
  logic [WAYW-1:0] fill_way;
  logic [NDXW-1:0] fill_ndx;
  logic            inv_v;
  logic [NDXW-1:0] inv_ndx;
  logic            inv_all;
  logic            hit_v;
  logic [WAYS-1:0] hits;
  logic            hit;
  logic [WAYW-1:0] rway;
  logic            multi_hit;
  logic [WAYW-1:0] victim;

  rfbw_dchit_nway #(
    .AWID(AWID), .WAYS(WAYS), .LINES(LINES), .LOBIT(LOBIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_v(req_v), .adr(adr),
    .tags(tags), .stall(stall), .fill_v(fill_v),
    .fill_way(fill_way), .fill_ndx(fill_ndx), .inv_v(inv_v),
    .inv_ndx(inv_ndx), .inv_all(inv_all), .hit_v(hit_v),
    .hits(hits), .hit(hit), .rway(rway),
    .multi_hit(multi_hit), .victim(victim)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];
  bit   mv[LINES][WAYS];
  int   mp[LINES];
  int   mrway;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [TAGW-1:0] mk_tag(int up, int n);
    return {UPW'(up), NDXW'(n)};
  endfunction

  function automatic logic [AWID-1:0] mk_adr(int up, int n);
    return {mk_tag(up, n), LOBIT'($urandom)};
  endfunction

  function automatic tg_t all_tags(logic [TAGW-1:0] t);
    tg_t r;
    for (int w = 0; w < WAYS; w++) r[w] = t;
    return r;
  endfunction

  function automatic tg_t one_tag(int w, logic [TAGW-1:0] t,
                                  logic [TAGW-1:0] o);
    tg_t r;
    r = all_tags(o);
    r[w] = t;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      mp[i] = 0;
      for (int w = 0; w < WAYS; w++) mv[i][w] = 1'b0;
    end
    mrway = 0;
    q.delete();
  endtask

  // One cycle of stimulus; expected lookup result goes to the queue,
  // then the model state advances as the clock edge will.
  task automatic cyc(bit rq, logic [AWID-1:0] a, tg_t tg, bit st,
                     bit fv, int fw, int fn, bit iv, int inn, bit ia);
    res_t e;
    int n, cnt;
    logic [TAGW-1:0] at;
    @(negedge clk);
    req_v = rq; adr = a; tags = tg; stall = st;
    fill_v = fv; fill_way = WAYW'(fw); fill_ndx = NDXW'(fn);
    inv_v = iv; inv_ndx = NDXW'(inn); inv_all = ia;
    if (rq && !st) begin
      at = a[AWID-1:LOBIT];
      n = int'(a[LOBIT+NDXW-1:LOBIT]);
      cnt = 0;
      e = '0;
      e.hv = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (mv[n][w] && tg[w] == at) begin
          e.hits[w] = 1'b1;
          if (cnt == 0) mrway = w;
          cnt++;
        end
      end
      e.hit  = cnt > 0;
      e.mh   = cnt > 1;
      e.rway = WAYW'(mrway);
      e.vic  = WAYW'(mp[n]);
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!mv[n][w]) e.vic = WAYW'(w);
      end
      q.push_back(e);
    end
    if (fv) mp[fn] = (mp[fn] + 1) % WAYS;
    if (ia) begin
      for (int i = 0; i < LINES; i++)
        for (int w = 0; w < WAYS; w++) mv[i][w] = 1'b0;
    end else begin
      if (fv && !(iv && inn == fn)) mv[fn][fw] = 1'b1;
      if (iv) for (int w = 0; w < WAYS; w++) mv[inn][w] = 1'b0;
    end
  endtask

  task automatic idle();
    cyc(0, '0, '0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(int w, int n);
    cyc(0, '0, '0, 0, 1, w, n, 0, 0, 0);
  endtask

  task automatic look(int up, int n, tg_t tg);
    cyc(1, mk_adr(up, n), tg, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  // Monitor: tracks what the outputs must show each cycle.
  initial begin
    res_t cur;
    logic s, r, rs;
    cur = '0;
    forever begin
      @(posedge clk);
      s = stall; r = req_v; rs = rst_n;
      #1;
      if (!rs) begin
        cur = '0;
      end else if (!s) begin
        if (r) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: result with empty queue");
          end else begin
            cur = q.pop_front();
          end
        end else begin
          cur.hv = 1'b0;
        end
      end
      check("outs", 32'({hit_v, hits, hit, rway, multi_hit, victim}),
            32'(cur));
    end
  end

  initial begin
    rst_n = 1'b0; req_v = 1'b0; adr = '0; tags = '0; stall = 1'b0;
    fill_v = 1'b0; fill_way = '0; fill_ndx = '0;
    inv_v = 1'b0; inv_ndx = '0; inv_all = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    look(1, 3, one_tag(0, mk_tag(1, 3), mk_tag(2, 3)));
    peek();
    check("d1_hit", 32'(hit), 0);
    check("d1_vic", 32'(victim), 0);

    fill(2, 5);
    look(1, 5, one_tag(2, mk_tag(1, 5), mk_tag(2, 5)));
    peek();
    check("d2_hits", 32'(hits), 32'b0100);
    check("d2_rway", 32'(rway), 2);

    for (int w = 0; w < WAYS; w++) fill(w, 9);
    look(3, 9, all_tags(mk_tag(2, 9)));
    peek();
    check("d3_rway_hold", 32'(rway), 2);
    check("d3_vic_wrap", 32'(victim), 0);
    fill(0, 9);
    look(3, 9, all_tags(mk_tag(2, 9)));
    peek();
    check("d3_vic_next", 32'(victim), 1);

    fill(1, 12);
    cyc(1, mk_adr(1, 12), one_tag(1, mk_tag(1, 12), mk_tag(2, 12)),
        0, 1, 2, 12, 1, 12, 0);
    peek();
    check("d4_old_valid", 32'(hit), 1);
    look(1, 12, one_tag(1, mk_tag(1, 12), mk_tag(2, 12)));
    peek();
    check("d4_inv_wins", 32'(hit), 0);

    fill(1, 20);
    fill(3, 20);
    look(1, 20, all_tags(mk_tag(1, 20)));
    peek();
    check("d5_rway", 32'(rway), 1);
    check("d5_multi", 32'(multi_hit), 1);

    cyc(1, mk_adr(2, 20), all_tags(mk_tag(2, 20)), 1, 0, 0, 0, 0, 0, 0);
    cyc(1, mk_adr(2, 20), all_tags(mk_tag(2, 20)), 1, 0, 0, 0, 0, 0, 0);
    peek();
    check("d6_stall_hv", 32'(hit_v), 1);
    check("d6_stall_rway", 32'(rway), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("d6_async_rst",
          32'({hit_v, hits, hit, rway, multi_hit, victim}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; req_v = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      tg_t tg;
      int n;
      n = $urandom_range(0, 3);
      for (int w = 0; w < WAYS; w++) tg[w] = mk_tag($urandom_range(0, 3), n);
      cyc($urandom_range(0, 2) != 0, mk_adr($urandom_range(0, 3), n), tg,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3),
          $urandom_range(0, 3),
          $urandom_range(0, 15) == 0, $urandom_range(0, 3),
          $urandom_range(0, 199) == 0);
    end
    idle();
    idle();
    peek();
    check("sb_drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
